resource_arbiter: RTL

Round-robin arbiter and sequencer that shares one fixed-latency, fully pipelined functional unit (multiplier, divider, memory port) among up to 16 requesters in generated datapaths. It accepts at most one operand per cycle and drives the unit with a `{valid, data}` bus in the same format `DataMux` inputs use. It tracks each issued operation's owner through the unit latency and returns the result with a one-cycle `done` pulse to the owning requester. It sits between the scheduled basic-block logic and a shared resource instance.

---
 rtl/resource_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/resource_arbiter.sv
// Round-robin arbiter and sequencer in front of one shared, fixed-latency,
// fully pipelined functional unit. It accepts one operand per cycle, tracks
// the owner of each issued operation through the unit latency, and returns
// the result with a one-cycle done pulse to that owner.
module resource_arbiter #(
    parameter int ParamNumRequesters = 4,
    parameter int InBitWidth         = 32,
    parameter int OutBitWidth        = InBitWidth,
    parameter int ParamUnitLatency   = 3
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [ParamNumRequesters-1:0]            req,
    input  logic [ParamNumRequesters*InBitWidth-1:0] req_data,
    output logic [ParamNumRequesters-1:0]            grant,
    output logic [InBitWidth:0]                      unit_in,
    input  logic [OutBitWidth-1:0]                   unit_out,
    output logic [OutBitWidth-1:0]                   result,
    output logic [ParamNumRequesters-1:0]            done
);

    localparam int N  = ParamNumRequesters;
    localparam int W  = InBitWidth;
    localparam int L  = ParamUnitLatency;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_nxt;
    logic [3:0]     sel;
    logic           found;
    logic           accept;
    logic [W-1:0]   operand;
    int             pos;
    int             nxt;

    // Tag stage 0 lines up with unit_in; stage L lines up with the cycle in
    // which unit_out carries the matching result, so the capture register
    // fires L+2 cycles after acceptance.
    logic [L:0]      tag_vld;
    logic [L:0][3:0] tag_own;

    // Round-robin pick: first requester at or after ptr (mod N) with req high.
    always_comb begin
        grant = '0;
        sel   = '0;
        found = 1'b0;
        pos   = 0;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                pos = int'(ptr) + k;
                if (pos >= N) pos = pos - N;
                for (int i = 0; i < N; i++) begin
                    if (!found && req[i] && (pos == i)) begin
                        found    = 1'b1;
                        grant[i] = 1'b1;
                        sel      = 4'(i);
                    end
                end
            end
        end
    end

    // Operand of the granted requester and the pointer value after it.
    always_comb begin
        operand = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) operand = req_data[i*W +: W];
        end
        accept = |(req & grant);
        nxt    = int'(sel) + 1;
        ptr_nxt = (nxt >= N) ? '0 : PW'(nxt);
    end

    // Priority pointer and issue register; unit_in data holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            unit_in <= '0;
        end else begin
            unit_in[W] <= accept;
            if (accept) begin
                ptr              <= ptr_nxt;
                unit_in[W-1:0]   <= operand;
            end
        end
    end

    // Owner tag shift register, advancing every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= accept;
            tag_own[0] <= sel;
            for (int k = 1; k <= L; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_own[k] <= tag_own[k-1];
            end
        end
    end

    // Capture the unit result and pulse done to its owner for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            done   <= '0;
        end else begin
            if (tag_vld[L]) begin
                result <= unit_out;
                for (int i = 0; i < N; i++) done[i] <= (tag_own[L] == 4'(i));
            end else begin
                done <= '0;
            end
        end
    end

endmodule
